// File: rtl/led_pwm_pkg.sv
// Shared types and constants for the AXI4-Lite LED PWM peripheral: channel modes,
// register offsets, response codes and the address-decode result.
package led_pwm_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_PRESCALE,
        SEL_STATUS,
        SEL_CHAN
    } reg_sel_t;

    typedef struct packed {
        reg_sel_t   sel;
        logic [2:0] idx;
    } reg_dec_t;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

    localparam int CTRL_OFS     = 'h00;
    localparam int PRESCALE_OFS = 'h04;
    localparam int STATUS_OFS   = 'h08;
    localparam int CHAN_BASE    = 'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: selects off/on/blink/PWM from the shared counter, registered output.
module led_pwm_chan
    import led_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  led_mode_t  mode,
    input  logic [7:0] duty,
    input  logic [7:0] cnt,
    output logic       led
);

    logic led_reg;
    logic led_next;

    always_comb begin
        led_next = 1'b0;
        if (en) begin
            case (mode)
                LED_OFF:   led_next = 1'b0;
                LED_ON:    led_next = 1'b1;
                LED_BLINK: led_next = cnt[7];
                LED_PWM:   led_next = (cnt < duty);
                default:   led_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_reg <= 1'b0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led = led_reg;

endmodule

// File: rtl/led_pwm_axil.sv
// AXI4-Lite LED controller: register file, prescaled tick, shared 8-bit counter and
// NUM_LEDS channels. Define LED_PWM_STATUS_EN to map the read-only STATUS register at 0x08.
module led_pwm_axil
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS           = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             led_o
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    wr_state_t         wr_state_reg, wr_state_next;
    rd_state_t         rd_state_reg, rd_state_next;
    logic [1:0]        bresp_reg;
    logic [1:0]        rresp_reg;
    logic [DW-1:0]     rdata_reg;
    logic              ctrl_en_reg;
    logic [15:0]       prescale_reg;
    logic [15:0]       presc_cnt_reg;
    logic [7:0]        cnt_reg;
    logic [NUM_LEDS-1:0] led_vec;
    logic [DW-1:0]     chan_rd_word [NUM_LEDS];
    reg_dec_t          wr_dec, rd_dec;
    logic              wr_fire, rd_fire, wr_ok;
    logic [DW-1:0]     rd_data;
    logic [1:0]        rd_resp;
    logic              unused_ok;

    // Low address bits are ignored; anything outside the map decodes to SEL_NONE.
    function automatic reg_dec_t decode(input logic [AW-1:0] addr);
        reg_dec_t      d;
        logic [AW-1:0] a;
        logic [AW-1:0] rel;
        d.sel = SEL_NONE;
        d.idx = '0;
        a     = {addr[AW-1:2], 2'b00};
        rel   = a - AW'(CHAN_BASE);
        if (a == AW'(CTRL_OFS)) begin
            d.sel = SEL_CTRL;
        end else if (a == AW'(PRESCALE_OFS)) begin
            d.sel = SEL_PRESCALE;
`ifdef LED_PWM_STATUS_EN
        end else if (a == AW'(STATUS_OFS)) begin
            d.sel = SEL_STATUS;
`endif
        end else if (a >= AW'(CHAN_BASE) && a < AW'(CHAN_BASE + 4 * NUM_LEDS)) begin
            d.sel = SEL_CHAN;
            d.idx = 3'(rel >> 2);
        end
        return d;
    endfunction

    assign wr_dec  = decode(S_AXI_AWADDR);
    assign rd_dec  = decode(S_AXI_ARADDR);
    assign wr_fire = (wr_state_reg == W_ACK);
    assign rd_fire = (rd_state_reg == R_ACK);
    assign wr_ok   = (wr_dec.sel == SEL_CTRL) || (wr_dec.sel == SEL_PRESCALE) ||
                     (wr_dec.sel == SEL_CHAN);

    // Write channel: both AW and W must be valid before the single-cycle accept.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_reg <= W_IDLE;
            bresp_reg    <= RESP_OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            if (wr_fire) begin
                bresp_reg <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (wr_state_reg)
            W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_next = W_ACK;
            W_ACK: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                wr_state_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign S_AXI_BRESP = bresp_reg;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_reg <= R_IDLE;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            if (rd_fire) begin
                rdata_reg <= rd_data;
                rresp_reg <= rd_resp;
            end
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rd_state_reg)
            R_IDLE: if (S_AXI_ARVALID) rd_state_next = R_ACK;
            R_ACK: begin
                S_AXI_ARREADY = 1'b1;
                rd_state_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) rd_state_next = R_IDLE;
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign S_AXI_RDATA = rdata_reg;
    assign S_AXI_RRESP = rresp_reg;

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        case (rd_dec.sel)
            SEL_CTRL: begin
                rd_data[0] = ctrl_en_reg;
                rd_resp    = RESP_OKAY;
            end
            SEL_PRESCALE: begin
                rd_data[15:0] = prescale_reg;
                rd_resp       = RESP_OKAY;
            end
`ifdef LED_PWM_STATUS_EN
            SEL_STATUS: begin
                rd_data[NUM_LEDS-1:0] = led_vec;
                rd_data[23:16]        = cnt_reg;
                rd_resp               = RESP_OKAY;
            end
`endif
            SEL_CHAN: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (rd_dec.idx == 3'(i)) rd_data = chan_rd_word[i];
                end
                rd_resp = RESP_OKAY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en_reg  <= 1'b0;
            prescale_reg <= '0;
        end else if (wr_fire) begin
            if (wr_dec.sel == SEL_CTRL && S_AXI_WSTRB[0]) ctrl_en_reg <= S_AXI_WDATA[0];
            if (wr_dec.sel == SEL_PRESCALE) begin
                if (S_AXI_WSTRB[0]) prescale_reg[7:0]  <= S_AXI_WDATA[7:0];
                if (S_AXI_WSTRB[1]) prescale_reg[15:8] <= S_AXI_WDATA[15:8];
            end
        end
    end

    // Disabled: counters parked at zero so enabling always starts a fresh period.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= '0;
        end else if (!ctrl_en_reg) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= '0;
        end else if (wr_fire && wr_dec.sel == SEL_PRESCALE) begin
            presc_cnt_reg <= '0;
        end else if (presc_cnt_reg == prescale_reg) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= cnt_reg + 8'd1;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        led_mode_t  mode_reg;
        logic [7:0] duty_reg;
        logic       chan_wr;

        assign chan_wr = wr_fire && (wr_dec.sel == SEL_CHAN) && (wr_dec.idx == 3'(gi));

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                mode_reg <= LED_OFF;
                duty_reg <= '0;
            end else if (chan_wr) begin
                if (S_AXI_WSTRB[0]) mode_reg <= led_mode_t'(S_AXI_WDATA[1:0]);
                if (S_AXI_WSTRB[1]) duty_reg <= S_AXI_WDATA[15:8];
            end
        end

        assign chan_rd_word[gi] = {16'h0000, duty_reg, 6'b000000, mode_reg};

        led_pwm_chan u_chan (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .en    (ctrl_en_reg),
            .mode  (mode_reg),
            .duty  (duty_reg),
            .cnt   (cnt_reg),
            .led   (led_vec[gi])
        );
    end

    assign led_o = led_vec;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA, S_AXI_WSTRB,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: doc/led_pwm_axil.md
# led_pwm_axil

AXI4-Lite slave driving NUM_LEDS LED outputs, each independently set to off, on, blink or 8-bit PWM from a shared prescaled tick. Parametrised successor of our fixed 4-register LED peripheral; it sits behind the PS/interconnect master port and drives board LED pins directly.

## Interface
- NUM_LEDS, 4, LED channels, legal 1..8
- C_S_AXI_DATA_WIDTH, 32, AXI data width, only 32 legal
- C_S_AXI_ADDR_WIDTH, 6, AXI byte address width, at least 6
- ACLK  in  1  clock; all logic on the rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data
- led_o  out  NUM_LEDS  LED drive, 1 = lit

## Operation
- Register map (word aligned, addr[1:0] ignored): 0x00 CTRL bit0 EN; 0x04 PRESCALE [15:0]; 0x08 STATUS (see Configuration); 0x10+4*i CHAN_i: [1:0] MODE, [15:8] DUTY. Unused bits read 0, writes ignored.
- MODE: 0 OFF led=0; 1 ON led=1; 2 BLINK led=cnt[7]; 3 PWM led=(cnt < DUTY).
- Tick generator: 16-bit prescaler counts 0..PRESCALE, tick on the cycle it equals PRESCALE, then reloads 0. PRESCALE=0 gives a tick every cycle. Any write to PRESCALE clears the prescaler counter.
- cnt: shared 8-bit counter, +1 per tick, wraps 255->0. PWM period 256 ticks; DUTY=0 never lit, DUTY=255 lit 255/256.
- EN=0: prescaler and cnt held at 0, led_o all 0 regardless of MODE. EN 0->1: counting restarts from 0.
- WSTRB honoured per byte on every writable register.
- Address decode: CHAN index >= NUM_LEDS, or any offset not listed -> write dropped with BRESP=SLVERR(2'b10); read returns 0 with RRESP=SLVERR. Valid accesses return OKAY.
- Write and read channels independent and may complete in the same cycle.

## Timing
- Reset: all registers 0 (EN=0, PRESCALE=0, MODE=OFF, DUTY=0); AWREADY, WREADY, ARREADY, BVALID, RVALID, led_o = 0; BRESP/RRESP/RDATA = 0.
- Write FSM: IDLE -> (AWVALID & WVALID) AWREADY=WREADY=1 for one cycle, register updated on that edge -> RESP BVALID=1 next cycle, held with BRESP stable until BREADY -> IDLE. AW without W (or W without AW) waits; no partial acceptance; one outstanding write.
- Read FSM: IDLE -> ARVALID: ARREADY=1 one cycle -> DATA RVALID=1 next cycle, RDATA/RRESP latched and stable until RREADY -> IDLE. One outstanding read.
- Register write to effect on led_o: 1 cycle (led_o registered).
- Read in same cycle as write to same register returns the old value.
- ARESETN low mid-transaction: both FSMs abort to IDLE, pending responses discarded.

## Configuration
- LED_PWM_STATUS_EN defined: 0x08 STATUS read-only, [NUM_LEDS-1:0]=current led_o, [23:16]=cnt; writes to it SLVERR.
- Undefined: 0x08 is unmapped (SLVERR on read and write), no status logic synthesised.

## Structure
- Package led_pwm_pkg: typedef enum logic [1:0] led_mode_t {LED_OFF, LED_ON, LED_BLINK, LED_PWM}; localparams for register offsets (CTRL, PRESCALE, STATUS, CHAN_BASE); RESP_OKAY/RESP_SLVERR.
- Sub-module led_pwm_chan: one per channel via generate; inputs mode, duty, cnt, en; registered led output. Top holds AXI FSMs, register file, prescaler and cnt.

## Test plan
- Reset: hold ARESETN low 200 ns -> all outputs 0, read 0x00/0x04/0x10 return 0 OKAY.
- Write CHAN0=0x1, CHAN1..3=0x0, CTRL=1 -> led_o=4'b0001 one cycle after CTRL B handshake; readback CHAN0=0x00000001.
- PRESCALE=0, CHAN2=0x4003 (PWM, DUTY=0x40), EN=1 -> led_o[2] high exactly 64 of every 256 cycles; DUTY=0 -> never high; DUTY=0xFF -> low 1 of 256.
- PRESCALE=1, CHAN3=0x2 (BLINK) -> led_o[3] toggles every 256 cycles (128 ticks x 2).
- Write 0x20 with NUM_LEDS=4 -> BRESP=SLVERR, no register changed; read 0x3C -> RDATA=0, RRESP=SLVERR.
- BREADY/RREADY held low 10 cycles, AWVALID asserted 3 cycles before WVALID -> BVALID/RVALID and data stable throughout, write accepted only when both valid; with LED_PWM_STATUS_EN, read 0x08 matches led_o.
